// File: rtl/block_plotter_if.sv
// Plot/erase handshake between the game controller and the block plotter,
// plus the plotter's pixel write port towards the VGA adapter.
interface block_plotter_if;
  logic       plot_req;
  logic       erase;
  logic [7:0] x_in;
  logic [6:0] y_in;
  logic [2:0] colour_in;
  logic [7:0] plot_x;
  logic [6:0] plot_y;
  logic [2:0] plot_colour;
  logic       plot_we;
  logic       done_plot;
  logic       busy;

  modport master (
    output plot_req, erase, x_in, y_in, colour_in,
    input  plot_x, plot_y, plot_colour, plot_we, done_plot, busy
  );

  modport slave (
    input  plot_req, erase, x_in, y_in, colour_in,
    output plot_x, plot_y, plot_colour, plot_we, done_plot, busy
  );
endinterface

// File: rtl/block_plotter.sv
// Walks a BLOCK_W x BLOCK_H rectangle one pixel per clock into the VGA write
// port on a plot request, clipping off-screen pixels, then reports done_plot.
module block_plotter #(
  parameter int         BLOCK_W   = 16,
  parameter int         BLOCK_H   = 4,
  parameter int         X_MAX     = 160,
  parameter int         Y_MAX     = 120,
  parameter logic [2:0] BG_COLOUR = 3'b000
) (
  input logic           clk,
  input logic           resetn,
  block_plotter_if.slave bus
);

  localparam int CX_W = (BLOCK_W > 1) ? $clog2(BLOCK_W) : 1;
  localparam int CY_W = (BLOCK_H > 1) ? $clog2(BLOCK_H) : 1;
  localparam logic [CX_W-1:0] CX_LAST = CX_W'(BLOCK_W - 1);
  localparam logic [CY_W-1:0] CY_LAST = CY_W'(BLOCK_H - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] DRAW = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]      state;
  logic [CX_W-1:0] cx;
  logic [CY_W-1:0] cy;
  logic [7:0]      x0;
  logic [6:0]      y0;
  logic [2:0]      col;

  logic [8:0] x_sum;
  logic [7:0] y_sum;
  logic       clipped;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= IDLE;
      cx    <= '0;
      cy    <= '0;
      x0    <= '0;
      y0    <= '0;
      col   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.plot_req) begin
            x0    <= bus.x_in;
            y0    <= bus.y_in;
            col   <= bus.erase ? BG_COLOUR : bus.colour_in;
            cx    <= '0;
            cy    <= '0;
            state <= DRAW;
          end
        end
        DRAW: begin
          if (!bus.plot_req) begin
            state <= IDLE;
          end else if (cx == CX_LAST) begin
            cx <= '0;
            // cy stays in range: the last row parks it at zero instead of wrapping past BLOCK_H
            if (cy == CY_LAST) begin
              cy    <= '0;
              state <= DONE;
            end else begin
              cy <= cy + 1'b1;
            end
          end else begin
            cx <= cx + 1'b1;
          end
        end
        DONE: begin
          if (!bus.plot_req) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign x_sum   = {1'b0, x0} + 9'(cx);
  assign y_sum   = {1'b0, y0} + 8'(cy);
  assign clipped = (x_sum >= 9'(X_MAX)) || (y_sum >= 8'(Y_MAX));

  // Write enable also follows plot_req so an abort suppresses the in-flight pixel
  always_comb begin
    bus.plot_x      = '0;
    bus.plot_y      = '0;
    bus.plot_colour = '0;
    bus.plot_we     = 1'b0;
    bus.done_plot   = 1'b0;
    bus.busy        = 1'b0;
    case (state)
      DRAW: begin
        bus.plot_x      = x_sum[7:0];
        bus.plot_y      = y_sum[6:0];
        bus.plot_colour = col;
        bus.plot_we     = bus.plot_req && !clipped;
        bus.busy        = 1'b1;
      end
      DONE: begin
        bus.done_plot = 1'b1;
        bus.busy      = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
